// File: rtl/spi_xfer_sequencer.sv
// spi_xfer_sequencer: frames an N-byte SPI transfer (CS_n setup/hold/idle) around a single-byte SPI master
// Ports:
//   i_Clk, i_Rst_L          clock, asynchronous active-low reset
//   i_Start, i_Len, i_Abort transfer request, byte count, early termination
//   o_Busy, o_Done, o_Aborted  status; o_Aborted qualifies o_Done
//   i_TX_Byte, o_TX_Next    upstream FWFT TX source and its pop strobe
//   o_RX_Byte, o_RX_DV      received byte and its valid pulse
//   o_M_TX_Byte, o_M_TX_DV, i_M_TX_Ready, i_M_RX_DV, i_M_RX_Byte  SPI master handshake
//   o_SPI_CS_n              active-low chip select
module spi_xfer_sequencer #(
    parameter int MAX_BYTES     = 16,
    parameter int CS_SETUP_CLKS = 2,
    parameter int CS_HOLD_CLKS  = 2,
    parameter int CS_IDLE_CLKS  = 4,
    localparam int CW           = $clog2(MAX_BYTES + 1)
) (
    input  logic          i_Clk,
    input  logic          i_Rst_L,
    input  logic          i_Start,
    input  logic [CW-1:0] i_Len,
    input  logic          i_Abort,
    output logic          o_Busy,
    output logic          o_Done,
    output logic          o_Aborted,
    input  logic [7:0]    i_TX_Byte,
    output logic          o_TX_Next,
    output logic [7:0]    o_RX_Byte,
    output logic          o_RX_DV,
    output logic [7:0]    o_M_TX_Byte,
    output logic          o_M_TX_DV,
    input  logic          i_M_TX_Ready,
    input  logic          i_M_RX_DV,
    input  logic [7:0]    i_M_RX_Byte,
    output logic          o_SPI_CS_n
);
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_LOAD, S_WAIT_RX, S_HOLD, S_GAP} state_t;

    state_t        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [CW-1:0] rem_q, rem_d;
    logic          pend_q, pend_d;
    logic          cs_n_d, done_d, aborted_d, tx_next_d, rx_dv_d, m_tx_dv_d;
    logic [7:0]    rx_byte_d, m_tx_byte_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        pend_d      = pend_q;
        cs_n_d      = o_SPI_CS_n;
        aborted_d   = o_Aborted;
        rx_byte_d   = o_RX_Byte;
        m_tx_byte_d = o_M_TX_Byte;
        done_d      = 1'b0;
        tx_next_d   = 1'b0;
        rx_dv_d     = 1'b0;
        m_tx_dv_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Out-of-range lengths are silently dropped; an abort here is discarded.
                if (i_Start && i_Len != '0 && i_Len <= CW'(MAX_BYTES)) begin
                    state_d   = S_SETUP;
                    cnt_d     = '0;
                    rem_d     = i_Len;
                    pend_d    = 1'b0;
                    cs_n_d    = 1'b0;
                    aborted_d = 1'b0;
                end
            end
            S_SETUP: begin
                if (i_Abort) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                    pend_d  = 1'b1;
                end else if (cnt_q == 8'(CS_SETUP_CLKS - 1)) begin
                    state_d = S_LOAD;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_LOAD: begin
                // Abort takes priority over a ready master so no further byte is issued.
                if (i_Abort) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                    pend_d  = 1'b1;
                end else if (i_M_TX_Ready) begin
                    m_tx_byte_d = i_TX_Byte;
                    m_tx_dv_d   = 1'b1;
                    tx_next_d   = 1'b1;
                    state_d     = S_WAIT_RX;
                end
            end
            S_WAIT_RX: begin
                // Ready is not looked at here: a stale Ready right after DV must not re-issue.
                if (i_Abort) pend_d = 1'b1;
                if (i_M_RX_DV) begin
                    rx_byte_d = i_M_RX_Byte;
                    rx_dv_d   = 1'b1;
                    rem_d     = rem_q - CW'(1);
                    state_d   = (rem_q == CW'(1) || pend_q || i_Abort) ? S_HOLD : S_LOAD;
                    cnt_d     = '0;
                end
            end
            S_HOLD: begin
                if (cnt_q == 8'(CS_HOLD_CLKS - 1)) begin
                    cs_n_d    = 1'b1;
                    done_d    = 1'b1;
                    aborted_d = pend_q;
                    state_d   = S_GAP;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_GAP: begin
                if (cnt_q == 8'(CS_IDLE_CLKS - 1)) state_d = S_IDLE;
                else cnt_d = cnt_q + 8'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            pend_q      <= 1'b0;
            o_Busy      <= 1'b0;
            o_Done      <= 1'b0;
            o_Aborted   <= 1'b0;
            o_TX_Next   <= 1'b0;
            o_RX_Byte   <= 8'h00;
            o_RX_DV     <= 1'b0;
            o_M_TX_Byte <= 8'h00;
            o_M_TX_DV   <= 1'b0;
            o_SPI_CS_n  <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            pend_q      <= pend_d;
            o_Busy      <= state_d != S_IDLE;
            o_Done      <= done_d;
            o_Aborted   <= aborted_d;
            o_TX_Next   <= tx_next_d;
            o_RX_Byte   <= rx_byte_d;
            o_RX_DV     <= rx_dv_d;
            o_M_TX_Byte <= m_tx_byte_d;
            o_M_TX_DV   <= m_tx_dv_d;
            o_SPI_CS_n  <= cs_n_d;
        end
    end
endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// tb_spi_xfer_sequencer: directed and randomized transfers against a transaction-level expectation model
module tb_spi_xfer_sequencer;
    localparam int MAX_BYTES     = 16;
    localparam int CS_SETUP_CLKS = 2;
    localparam int CS_HOLD_CLKS  = 2;
    localparam int CS_IDLE_CLKS  = 4;
    localparam int CW            = $clog2(MAX_BYTES + 1);

    logic          i_Clk = 1'b0;
    logic          i_Rst_L = 1'b0;
    logic          i_Start = 1'b0;
    logic [CW-1:0] i_Len = '0;
    logic          i_Abort = 1'b0;
    logic          o_Busy, o_Done, o_Aborted, o_TX_Next, o_RX_DV, o_M_TX_DV, o_SPI_CS_n;
    logic [7:0]    i_TX_Byte = 8'hEE;
    logic [7:0]    o_RX_Byte, o_M_TX_Byte;
    logic          i_M_TX_Ready = 1'b1;
    logic          i_M_RX_DV = 1'b0;
    logic [7:0]    i_M_RX_Byte = 8'h00;

    always #5 i_Clk = ~i_Clk;

    spi_xfer_sequencer #(
        .MAX_BYTES(MAX_BYTES), .CS_SETUP_CLKS(CS_SETUP_CLKS),
        .CS_HOLD_CLKS(CS_HOLD_CLKS), .CS_IDLE_CLKS(CS_IDLE_CLKS)
    ) dut (
        .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Start(i_Start), .i_Len(i_Len), .i_Abort(i_Abort),
        .o_Busy(o_Busy), .o_Done(o_Done), .o_Aborted(o_Aborted),
        .i_TX_Byte(i_TX_Byte), .o_TX_Next(o_TX_Next), .o_RX_Byte(o_RX_Byte), .o_RX_DV(o_RX_DV),
        .o_M_TX_Byte(o_M_TX_Byte), .o_M_TX_DV(o_M_TX_DV), .i_M_TX_Ready(i_M_TX_Ready),
        .i_M_RX_DV(i_M_RX_DV), .i_M_RX_Byte(i_M_RX_Byte), .o_SPI_CS_n(o_SPI_CS_n)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fall_cnt, rise_cnt, dv_cnt, txn_cnt, rx_cnt, done_cnt, t_fall, t_rise, t_dv1, t_rx;
    logic busy_seen, last_aborted, cs_prev;
    logic [7:0] xfer_tx [MAX_BYTES];
    logic [7:0] rx_xor;
    logic [7:0] src_q [$];
    logic m_pend;
    int m_delay;
    logic [7:0] m_byte;
    int abort_at;
    logic abort_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_counters();
        fall_cnt = 0; rise_cnt = 0; dv_cnt = 0; txn_cnt = 0; rx_cnt = 0; done_cnt = 0;
        t_fall = -1; t_rise = -1; t_dv1 = -1; t_rx = -1;
        busy_seen = 0; last_aborted = 0; abort_at = 0; abort_done = 0;
    endtask

    task automatic reset_master();
        m_pend = 0; m_delay = 0; i_M_RX_DV = 0; i_M_TX_Ready = 1;
    endtask

    task automatic prep(input int len, input logic [7:0] x);
        src_q.delete();
        for (int i = 0; i < len; i++) src_q.push_back(xfer_tx[i]);
        src_q.push_back(8'hEE);
        i_TX_Byte = src_q[0];
        rx_xor = x;
        clear_counters();
    endtask

    // One clock: observe DUT at the falling edge, then play the SPI master, FWFT source and abort driver.
    task automatic step();
        @(negedge i_Clk);
        cyc++;
        if (o_SPI_CS_n !== cs_prev) begin
            if (o_SPI_CS_n === 1'b0) begin fall_cnt++; t_fall = cyc; end
            else begin rise_cnt++; t_rise = cyc; end
            cs_prev = o_SPI_CS_n;
        end
        if (o_Busy) busy_seen = 1;
        if (o_M_TX_DV) begin
            chk("dv_while_outstanding", m_pend, 0);
            chk("tx_next_with_dv", o_TX_Next, 1);
            chk("m_tx_byte", o_M_TX_Byte, xfer_tx[dv_cnt % MAX_BYTES]);
            if (dv_cnt == 0) t_dv1 = cyc;
            dv_cnt++;
        end
        if (o_TX_Next) begin
            txn_cnt++;
            if (src_q.size() > 0) src_q.delete(0);
        end
        if (o_RX_DV) begin
            chk("rx_byte", o_RX_Byte, xfer_tx[rx_cnt % MAX_BYTES] ^ rx_xor);
            rx_cnt++;
            t_rx = cyc;
        end
        if (o_Done) begin
            done_cnt++;
            last_aborted = o_Aborted;
            chk("cs_high_at_done", o_SPI_CS_n, 1);
        end
        i_M_RX_DV = 0;
        if (o_M_TX_DV) begin
            m_pend = 1;
            m_byte = o_M_TX_Byte;
            m_delay = $urandom_range(1, 5);
            i_M_TX_Ready = 0;
        end else if (m_pend) begin
            m_delay--;
            i_M_TX_Ready = 1'($urandom_range(0, 1));
            if (m_delay == 0) begin
                i_M_RX_DV = 1;
                i_M_RX_Byte = m_byte ^ rx_xor;
                m_pend = 0;
            end
        end else if (!i_M_TX_Ready) begin
            i_M_TX_Ready = ($urandom_range(0, 2) == 0);
        end
        i_TX_Byte = src_q.size() > 0 ? src_q[0] : 8'hEE;
        i_Abort = 0;
        if (abort_at > 0 && !abort_done && m_pend && dv_cnt == abort_at) begin
            i_Abort = 1;
            abort_done = 1;
        end
    endtask

    // ab: 0 none, k>0 abort while byte k is in flight, -1 abort during SETUP
    task automatic run_xfer(input int len, input int ab, input logic start_abort, input logic [7:0] x);
        int n, t_start, exp_n;
        prep(len, x);
        abort_at = ab;
        n = 0;
        while (i_M_TX_Ready !== 1'b1 && n < 50) begin step(); n++; end
        i_Start = 1; i_Len = CW'(len); i_Abort = start_abort;
        t_start = cyc;
        step();
        i_Start = 0;
        chk("cs_fall_latency", t_fall - t_start, 1);
        chk("aborted_clr_on_start", o_Aborted, 0);
        if (ab < 0) i_Abort = 1;
        n = 0;
        while (done_cnt == 0 && n < 2000) begin step(); n++; end
        chk("done_timeout", n < 2000, 1);
        n = 0;
        while (o_Busy && n < 50) begin step(); n++; end
        chk("gap_len", cyc - t_rise, CS_IDLE_CLKS);
        step();
        exp_n = ab < 0 ? 0 : (ab > 0 ? ab : len);
        chk("dv_count", dv_cnt, exp_n);
        chk("tx_next_count", txn_cnt, exp_n);
        chk("rx_count", rx_cnt, exp_n);
        chk("done_count", done_cnt, 1);
        chk("aborted_flag", last_aborted, ab != 0);
        chk("cs_falls", fall_cnt, 1);
        chk("cs_rises", rise_cnt, 1);
        if (exp_n > 0) begin
            chk("first_dv_latency", t_dv1 - t_fall, CS_SETUP_CLKS + 1);
            chk("hold_len", t_rise - t_rx, CS_HOLD_CLKS);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cs_n"}, o_SPI_CS_n, 1);
        chk({tag, "_busy"}, o_Busy, 0);
        chk({tag, "_done"}, o_Done, 0);
        chk({tag, "_aborted"}, o_Aborted, 0);
        chk({tag, "_tx_next"}, o_TX_Next, 0);
        chk({tag, "_rx_dv"}, o_RX_DV, 0);
        chk({tag, "_m_tx_dv"}, o_M_TX_DV, 0);
        chk({tag, "_rx_byte"}, o_RX_Byte, 8'h00);
        chk({tag, "_m_tx_byte"}, o_M_TX_Byte, 8'h00);
    endtask

    initial begin
        int n, len, ab;
        cs_prev = 1;
        reset_master();
        clear_counters();
        repeat (3) @(negedge i_Clk);
        chk_reset_outputs("reset");
        i_Rst_L = 1;
        step(); step();

        xfer_tx[0] = 8'hA5;
        run_xfer(1, 0, 0, 8'h00);
        chk("loopback_a5", o_RX_Byte, 8'hA5);

        for (int i = 0; i < 4; i++) xfer_tx[i] = 8'(i + 1);
        run_xfer(4, 0, 0, 8'h00);
        chk("last_rx_04", o_RX_Byte, 8'h04);

        clear_counters();
        i_Start = 1; i_Len = CW'(0); step(); i_Start = 0;
        repeat (6) step();
        i_Start = 1; i_Len = CW'(MAX_BYTES + 1); step(); i_Start = 0;
        repeat (6) step();
        chk("bad_len_falls", fall_cnt, 0);
        chk("bad_len_busy", busy_seen, 0);

        for (int i = 0; i < MAX_BYTES; i++) xfer_tx[i] = 8'($urandom);
        run_xfer(3, 2, 0, 8'($urandom));
        run_xfer(5, -1, 0, 8'($urandom));
        chk("aborted_held_after_done", o_Aborted, 1);
        run_xfer(2, 0, 1, 8'($urandom));

        // back-to-back: start held high through the whole first transfer and its gap
        for (int i = 0; i < 3; i++) xfer_tx[i] = 8'($urandom);
        prep(3, 8'($urandom));
        i_Start = 1; i_Len = CW'(2);
        step();
        i_Len = CW'(1);
        n = 0;
        while (fall_cnt < 2 && n < 500) begin step(); n++; end
        i_Start = 0;
        chk("b2b_timeout", n < 500, 1);
        chk("b2b_second_fall", t_fall - t_rise, CS_IDLE_CLKS + 1);
        n = 0;
        while ((done_cnt < 2 || o_Busy) && n < 500) begin step(); n++; end
        chk("b2b_dv_count", dv_cnt, 3);
        chk("b2b_rx_count", rx_cnt, 3);
        chk("b2b_done_count", done_cnt, 2);

        // reset while byte 2 is in flight
        for (int i = 0; i < 3; i++) xfer_tx[i] = 8'($urandom);
        prep(3, 8'($urandom));
        i_Start = 1; i_Len = CW'(3);
        step();
        i_Start = 0;
        n = 0;
        while (!(dv_cnt == 2 && m_pend) && n < 500) begin step(); n++; end
        chk("rst_mid_reach_timeout", n < 500, 1);
        #2 i_Rst_L = 0;
        #1 chk_reset_outputs("rst_mid");
        reset_master();
        i_Rst_L = 1;
        repeat (8) step();
        chk("rst_mid_no_done", done_cnt, 0);
        xfer_tx[0] = 8'($urandom);
        run_xfer(1, 0, 0, 8'($urandom));

        for (int k = 0; k < 8; k++) begin
            len = $urandom_range(1, MAX_BYTES);
            ab = (len > 1 && $urandom_range(0, 2) == 0) ? $urandom_range(1, len - 1) : 0;
            for (int i = 0; i < MAX_BYTES; i++) xfer_tx[i] = 8'($urandom);
            run_xfer(len, ab, 0, 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
